pipe_reg: RTL and testbench
===========================

# pipe_reg

Parametrised elastic pipeline register: the next generation of the team's single-stage falling-edge D register. Carries a WIDTH-bit word through DEPTH register stages, each with its own valid bit, under valid/ready flow control with bubble collapsing, synchronous flush, and asynchronous reset. Sits between producer and consumer datapath blocks wherever a fixed-latency, stall-capable delay of a data bus is needed.

## Interface
- WIDTH, 5, data word width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- CLK  input  1  clock; one clock, all state updates on the falling edge
- RST  input  1  asynchronous, active-high reset
- D  input  WIDTH  input data word
- IN_VALID  input  1  D holds a word to accept
- IN_READY  output  1  block accepts D at this falling edge
- Q  output  WIDTH  data of the last stage (stage DEPTH-1)
- OUT_VALID  output  1  Q holds a valid word
- OUT_READY  input  1  consumer takes Q at this falling edge
- FLUSH  input  1  synchronous discard of all held words
- COUNT  output  $clog2(DEPTH+1)  number of valid stages (present only with PIPE_REG_COUNT_EN)

## Operation
- Stages 0..DEPTH-1; each has valid bit v[i] and data register d[i]. Upstream of stage 0 is (IN_VALID, D).
- Ready chain (combinational): r[DEPTH] = OUT_READY; r[i] = !v[i] | r[i+1]. IN_READY = r[0] & !FLUSH.
- At each falling edge, if r[i]: v[i] <= upstream valid; d[i] <= upstream data only when upstream valid is 1, otherwise d[i] holds.
- If !r[i]: stage i holds both v[i] and d[i].
- Input handshake: IN_VALID & IN_READY at a falling edge. Output handshake: OUT_VALID & OUT_READY at a falling edge.
- Bubble collapsing: an empty stage always accepts, so gaps close up behind a stalled output; DEPTH words can be held.
- Order preserved; no word dropped or duplicated except by FLUSH or RST.
- Q = d[DEPTH-1], OUT_VALID = v[DEPTH-1]; Q holds last loaded value when OUT_VALID = 0.
- FLUSH = 1 at a falling edge: all v[i] <= 0; d[i] unchanged; IN_READY forced 0 (no input accepted); an output handshake at that same edge counts as completed.
- No arithmetic on data; block is data-transparent.

## Timing
- Reset (asynchronous, immediate on RST rising): all v[i] = 0, all d[i] = 0; hence OUT_VALID = 0, Q = 0, COUNT = 0, IN_READY = 1 (if FLUSH = 0). Reset mid-stream discards all words.
- First falling edge after RST deasserts is a normal edge.
- Latency: a word accepted at falling edge n appears on Q with OUT_VALID = 1 after edge n+DEPTH-1 (DEPTH register stages), when never stalled.
- Throughput: one word per falling edge with OUT_READY held 1.
- Full (all v = 1) with OUT_READY = 0: IN_READY = 0. Full with OUT_READY = 1: IN_READY = 1, simultaneous in and out, COUNT unchanged.
- IN_READY has a combinational path from OUT_READY and FLUSH; OUT_VALID, Q, COUNT are registered-only.

## Configuration
- PIPE_REG_COUNT_EN defined: COUNT port present, equal to popcount of v[0..DEPTH-1], combinational from registers, 0 in reset.
- Undefined: COUNT port and its logic absent; all other behaviour identical.

## Structure
- Shared package pipe_pkg: default WIDTH/DEPTH constants and the count-width function (ceil log2 of DEPTH+1).
- One sub-module natural: pipe_stage (one valid bit + WIDTH data register, load/hold control, asynchronous RST, falling-edge CLK); pipe_reg instantiates DEPTH of them in a generate loop plus the ready chain and optional counter.

## Test plan
- Reset: stream running, assert RST between edges -> OUT_VALID = 0, Q = 5'h00, COUNT = 0 immediately, before next edge.
- Streaming (WIDTH 5, DEPTH 4): IN_VALID = 1, OUT_READY = 1, D = 0,1,...,14 per edge -> Q = 0 valid after 4th edge, then 1..14 on consecutive edges, IN_READY constantly 1.
- Backpressure: OUT_READY = 0, offer 6 words 5'h01..5'h06 -> first 4 accepted, IN_READY = 0, COUNT = 4, Q = 5'h01; set OUT_READY = 1 -> 01..06 emerge in order, no gap.
- Bubble collapse: OUT_READY = 0, push 5'h03, idle 2 edges, push 5'h1F -> stages 3 and 2 hold 03, 1F, COUNT = 2, IN_READY stays 1.
- Flush while full: FLUSH = 1 one edge with IN_VALID = 1 -> IN_READY = 0, then OUT_VALID = 0, COUNT = 0, Q keeps last data, IN_READY = 1 next cycle.
- DEPTH = 1: push 5'h0A with OUT_READY = 0 -> OUT_VALID = 1 after one edge, IN_READY = 0 until OUT_READY = 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
// Default word width and depth, and the width of the occupancy count.
package pipe_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_DEPTH = 4;

  // Bits needed to hold a value in 0..depth (ceil log2 of depth+1).
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// State updates on the falling edge of CLK; RST clears everything at once.
// flush drops the valid bit but keeps the data; data only reloads when the
// upstream word is valid, so an empty stage keeps its last loaded value.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load from upstream when allowed, hold otherwise; flush empties the stage.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH pipe_stage instances under valid/ready
// flow control with bubble collapsing and synchronous flush.
// Handshake: a word moves across an interface at a falling edge exactly
// when valid and ready are both 1 there; valid never waits on ready.
// Optional feature: define PIPE_REG_COUNT_EN to add the COUNT port
// (number of occupied stages).
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Q,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             FLUSH
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] COUNT
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   r;

  // Ready chain: a stage can load if it is empty or its successor can load,
  // which is what lets bubbles close up behind a stalled output.
  always_comb begin
    r        = '0;
    r[DEPTH] = OUT_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = !v[i] || r[i+1];
    end
  end

  assign IN_READY  = r[0] && !FLUSH;
  assign Q         = d[DEPTH-1];
  assign OUT_VALID = v[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = IN_VALID;
      assign up_d = D;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .CLK      (CLK),
      .RST      (RST),
      .load     (r[i]),
      .flush    (FLUSH),
      .up_valid (up_v),
      .up_data  (up_d),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

`ifdef PIPE_REG_COUNT_EN
  localparam int CW = cnt_w(DEPTH);

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    COUNT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      COUNT = COUNT + CW'(v[i]);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: a DEPTH=4 instance driven by directed phases and
// random traffic against a queue-based model, plus a DEPTH=1 instance.
module tb_pipe_reg;

  localparam int W  = 5;
  localparam int DP = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [W-1:0] d         = '0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] q;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         flush     = 1'b0;

  logic [W-1:0] d1        = '0;
  logic         iv1       = 1'b0;
  logic         ir1;
  logic [W-1:0] q1;
  logic         ov1;
  logic         or1       = 1'b0;
  logic         fl1       = 1'b0;

`ifdef PIPE_REG_COUNT_EN
  logic [2:0] count;
  logic [0:0] count1;
`endif

  pipe_reg #(.WIDTH(W), .DEPTH(DP)) dut (
    .CLK       (clk),
    .RST       (rst),
    .D         (d),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .Q         (q),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .FLUSH     (flush)
`ifdef PIPE_REG_COUNT_EN
    ,
    .COUNT     (count)
`endif
  );

  pipe_reg #(.WIDTH(W), .DEPTH(1)) dut1 (
    .CLK       (clk),
    .RST       (rst),
    .D         (d1),
    .IN_VALID  (iv1),
    .IN_READY  (ir1),
    .Q         (q1),
    .OUT_VALID (ov1),
    .OUT_READY (or1),
    .FLUSH     (fl1)
`ifdef PIPE_REG_COUNT_EN
    ,
    .COUNT     (count1)
`endif
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           held     = 0;
  logic         acc_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One falling-edge cycle: drive inputs after the rising edge, predict
  // IN_READY from occupancy, record the accepted word, update occupancy.
  task automatic step(input logic iv, input logic [W-1:0] dv, input logic ordy,
                      input logic fl, output logic acc);
    logic exp_rdy;
    logic pop;
    @(posedge clk);
    #1;
    in_valid  = iv;
    d         = dv;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && (held < DP || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef PIPE_REG_COUNT_EN
    chk("count", 32'(count), 32'(held));
`endif
    if (held == 0) chk("out_valid_when_empty", 32'(out_valid), 32'd0);
    acc = iv && exp_rdy;
    pop = out_valid && ordy;
    if (acc) exp_q.push_back(dv);
    @(negedge clk);
    #1;
    if (fl) begin
      held = 0;
      exp_q.delete();
    end else begin
      held = held + int'(acc) - int'(pop);
    end
  endtask

  // Reset asserted between edges must clear outputs immediately.
  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst1_out_valid", 32'(ov1), 32'd0);
    chk("rst1_q", 32'(q1), 32'd0);
`ifdef PIPE_REG_COUNT_EN
    chk("rst_count", 32'(count), 32'd0);
    chk("rst1_count", 32'(count1), 32'd0);
`endif
    exp_q.delete();
    held = 0;
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 2; i++) step(1'b0, '0, 1'b1, 1'b0, acc_t);
  endtask

  // ---------------- monitor ----------------
  // Every output handshake must deliver the oldest outstanding word.
  always @(posedge clk) begin
    logic [W-1:0] exp_w;
    #3;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected no word at %0t", q, $time);
      end else begin
        exp_w = exp_q.pop_front();
        chk("q_data", 32'(q), 32'(exp_w));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    logic iv, ordy, fl;
    logic [W-1:0] dv;

    // power-on reset
    #2;
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_q", 32'(q), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // streaming 0..14 with OUT_READY held: fixed latency, no stalls
    for (int k = 0; k < 19; k++) begin
      step(k < 15, W'(k), 1'b1, 1'b0, acc_t);
      chk("stream_valid", 32'(out_valid), 32'(k >= 3 && k <= 17));
      if (k >= 3 && k <= 17) chk("stream_q", 32'(q), 32'(k - 3));
    end

    // backpressure: offer 01..06 with the output stalled
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      step(idx < 6, W'(idx + 1), 1'b0, 1'b0, acc_t);
      if (acc_t) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_q", 32'(q), 32'h01);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
`ifdef PIPE_REG_COUNT_EN
    chk("bp_count", 32'(count), 32'd4);
`endif
    for (int s = 0; s < 8; s++) begin
      step(idx < 6, W'(idx + 1), 1'b1, 1'b0, acc_t);
      if (acc_t) idx++;
      if (s <= 5) chk("bp_no_gap", 32'(out_valid), 32'(s < 5));
    end

    // bubble collapse behind a stalled output
    step(1'b1, 5'h03, 1'b0, 1'b0, acc_t);
    step(1'b0, '0, 1'b0, 1'b0, acc_t);
    step(1'b0, '0, 1'b0, 1'b0, acc_t);
    step(1'b1, 5'h1f, 1'b0, 1'b0, acc_t);
    step(1'b0, '0, 1'b0, 1'b0, acc_t);
    step(1'b0, '0, 1'b0, 1'b0, acc_t);
    chk("bubble_q", 32'(q), 32'h03);
    chk("bubble_out_valid", 32'(out_valid), 32'd1);
`ifdef PIPE_REG_COUNT_EN
    chk("bubble_count", 32'(count), 32'd2);
`endif
    drain();

    // flush while full
    for (int s = 0; s < 4; s++) step(1'b1, W'(8'h11 + s), 1'b0, 1'b0, acc_t);
    chk("full_q", 32'(q), 32'h11);
    step(1'b1, 5'h15, 1'b0, 1'b1, acc_t);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_q_kept", 32'(q), 32'h11);
`ifdef PIPE_REG_COUNT_EN
    chk("flush_count", 32'(count), 32'd0);
`endif
    step(1'b0, '0, 1'b1, 1'b0, acc_t);

    // DEPTH=1 instance
    @(posedge clk);
    #1;
    iv1 = 1'b1;
    d1  = 5'h0a;
    or1 = 1'b0;
    #1;
    chk("d1_in_ready_empty", 32'(ir1), 32'd1);
    @(negedge clk);
    #1;
    iv1 = 1'b0;
    chk("d1_out_valid", 32'(ov1), 32'd1);
    chk("d1_q", 32'(q1), 32'h0a);
    chk("d1_in_ready_full", 32'(ir1), 32'd0);
    @(negedge clk);
    #1;
    chk("d1_in_ready_stall", 32'(ir1), 32'd0);
    chk("d1_q_hold", 32'(q1), 32'h0a);
    or1 = 1'b1;
    #1;
    chk("d1_in_ready_release", 32'(ir1), 32'd1);
    @(negedge clk);
    #1;
    chk("d1_out_valid_drained", 32'(ov1), 32'd0);
    or1 = 1'b0;

    // random traffic with an occasional flush and one mid-stream reset
    for (int s = 0; s < 400; s++) begin
      if (s == 200) do_reset();
      iv   = ($urandom_range(0, 3) != 0);
      dv   = W'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      step(iv, dv, ordy, fl, acc_t);
    end
    drain();
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
